conv3x3_engine: RTL and testbench

- Sequential 3x3 convolution stage that consumes the 6x6 binary matrix assembled by the switch-loader top level and produces a 4x4 feature map (valid convolution, stride 1).
- Snapshots image and kernel on `start`, then walks the 16 window positions row-major. Each result goes out on a valid/ready stream towards the display/readout stage.
- Computes one window per pass through a COMPUTE/OUTPUT state pair, with backpressure.

---
 rtl/conv3x3_engine_pkg.sv | 21 ++
 rtl/conv3x3_engine_if.sv | 29 ++
 rtl/conv3x3_engine_mac.sv | 20 ++
 rtl/conv3x3_engine.sv | 140 ++++++++++++++
 tb/tb_conv3x3_engine.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv3x3_engine_pkg.sv
// Shared constants, FSM state encoding and indexing helper for the 3x3 convolution engine.
package conv_pkg;

  localparam int IMG_N   = 6;
  localparam int K_N     = 3;
  localparam int OUT_N   = IMG_N - K_N + 1;
  localparam int NUM_OUT = OUT_N * OUT_N;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  // Flat bit position of pixel (r,c) in a row-major n x n image vector.
  function automatic int pix_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/conv3x3_engine_if.sv
// Result stream from the convolution engine to the readout stage.
// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready; the master
// holds out_data/out_idx stable while out_valid is high and not yet accepted, and out_ready
// has no effect while out_valid is low.
interface conv3x3_engine_if #(
  parameter int ACC_W = 8
) ();
  import conv_pkg::*;

  logic signed [ACC_W-1:0]           out_data;
  logic        [$clog2(NUM_OUT)-1:0] out_idx;
  logic                              out_valid;
  logic                              out_ready;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/conv3x3_engine_mac.sv
// Combinational 3x3 binary-pixel multiply-accumulate: sums the weights whose pixel is set.
module conv_window_mac #(
  parameter int W_BITS = 4,
  parameter int ACC_W  = W_BITS + 4
) (
  input  logic        [8:0]          pix_i,
  input  logic        [9*W_BITS-1:0] w_i,
  output logic signed [ACC_W-1:0]    sum_o
);

  always_comb begin
    sum_o = '0;
    for (int k = 0; k < 9; k++) begin
      if (pix_i[k]) begin
        sum_o = sum_o + ACC_W'($signed(w_i[k*W_BITS +: W_BITS]));
      end
    end
  end

endmodule

// File: rtl/conv3x3_engine.sv
// Sequential valid-convolution stage: snapshots a binary image and 3x3 kernel on start and
// streams one window sum per COMPUTE/OUTPUT pass, row-major, with backpressure.
module conv3x3_engine
  import conv_pkg::*;
#(
  parameter int IMG_N  = 6,
  parameter int W_BITS = 4,
  parameter int ACC_W  = W_BITS + 4,
  parameter int RELU   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [IMG_N*IMG_N-1:0]   img_in,
  input  logic [9*W_BITS-1:0]      kernel_in,
  conv3x3_engine_if.master         out_if,
  output logic                     busy,
  output logic                     done,
  output state_t                   dbg_state
);

  localparam int CW = $clog2(OUT_N);
  localparam int PW = $clog2(IMG_N * IMG_N);
  localparam int IW = $clog2(NUM_OUT);
  localparam logic [CW-1:0] LAST = CW'(OUT_N - 1);

  state_t                   state_q, state_d;
  logic [CW-1:0]            r_q, c_q;
  logic [IMG_N*IMG_N-1:0]   img_q;
  logic [9*W_BITS-1:0]      ker_q;
  logic signed [ACC_W-1:0]  data_q;
  logic [IW-1:0]            idx_q;
  logic                     valid_q;

  logic [8:0]               win;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  result;
  logic                     hs;

  assign hs = valid_q && out_if.out_ready;

  // Gather the 9 pixels under the current window from the snapshot.
  always_comb begin
    win = '0;
    for (int kr = 0; kr < K_N; kr++) begin
      for (int kc = 0; kc < K_N; kc++) begin
        win[kr*K_N + kc] = img_q[PW'(pix_idx(int'(r_q) + kr, int'(c_q) + kc, IMG_N))];
      end
    end
  end

  conv_window_mac #(
    .W_BITS (W_BITS),
    .ACC_W  (ACC_W)
  ) u_mac (
    .pix_i (win),
    .w_i   (ker_q),
    .sum_o (sum)
  );

  assign result = ((RELU != 0) && (sum < 0)) ? '0 : sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_COMPUTE;
      ST_COMPUTE: state_d = ST_OUTPUT;
      ST_OUTPUT: begin
        if (hs) begin
          state_d = ((r_q == LAST) && (c_q == LAST)) ? ST_FINISH : ST_COMPUTE;
        end
      end
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_FINISH);
    dbg_state = state_q;
  end

  // Datapath: snapshots, window counters and the registered result beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      c_q     <= '0;
      img_q   <= '0;
      ker_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            img_q <= img_in;
            ker_q <= kernel_in;
            r_q   <= '0;
            c_q   <= '0;
          end
        end
        ST_COMPUTE: begin
          data_q  <= result;
          idx_q   <= IW'(int'(r_q) * OUT_N + int'(c_q));
          valid_q <= 1'b1;
        end
        ST_OUTPUT: begin
          if (hs) begin
            valid_q <= 1'b0;
            if (c_q != LAST) begin
              c_q <= c_q + 1'b1;
            end else if (r_q != LAST) begin
              c_q <= '0;
              r_q <= r_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_idx   = idx_q;
  assign out_if.out_valid = valid_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine: one RELU=0 and one RELU=1 instance share the stimulus.
module tb_conv3x3_engine;
  import conv_pkg::*;

  localparam int ACC_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [35:0] img_in = '0;
  logic [35:0] kernel_in = '0;
  logic        busy0, done0, busy1, done1;
  state_t      st0, st1;

  conv3x3_engine_if #(.ACC_W(ACC_W)) bus0 ();
  conv3x3_engine_if #(.ACC_W(ACC_W)) bus1 ();
  assign bus0.out_ready = out_ready;
  assign bus1.out_ready = out_ready;

  conv3x3_engine #(.IMG_N(6), .W_BITS(4), .ACC_W(ACC_W), .RELU(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .img_in(img_in), .kernel_in(kernel_in),
    .out_if(bus0.master), .busy(busy0), .done(done0), .dbg_state(st0)
  );

  conv3x3_engine #(.IMG_N(6), .W_BITS(4), .ACC_W(ACC_W), .RELU(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .img_in(img_in), .kernel_in(kernel_in),
    .out_if(bus1.master), .busy(busy1), .done(done1), .dbg_state(st1)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] got_data[16];
  logic [ACC_W-1:0] got_relu[16];
  logic [3:0]       got_idx[16];
  int n_out, n_done, done_gap, busy_gap, timed_out;

  localparam logic [35:0] ONES_IMG  = 36'hF_FFFF_FFFF;
  localparam logic [35:0] PLUS1_KER = 36'h1_1111_1111;
  localparam logic [35:0] MIXED_IMG = 36'hB_5E3C_9A61;

  function automatic int ref_sum(input logic [35:0] img, input logic [35:0] ker,
                                 input int r, input int c);
    int s = 0;
    logic [3:0] w;
    for (int kr = 0; kr < 3; kr++) begin
      for (int kc = 0; kc < 3; kc++) begin
        w = ker[(kr*3+kc)*4 +: 4];
        if (img[(r+kr)*6 + (c+kc)]) s += $signed(w);
      end
    end
    return s;
  endfunction

  function automatic logic [35:0] ramp_kernel();
    logic [35:0] k = '0;
    for (int i = 0; i < 9; i++) k[i*4 +: 4] = 4'(i - 4);
    return k;
  endfunction

  // driver: runs one frame with out_ready high, recording every accepted beat
  task automatic run_frame(input logic [35:0] img, input logic [35:0] ker, input bit mutate);
    int cyc = 0;
    int last_hs = -100;
    int done_cyc = -200;
    n_out = 0; n_done = 0; busy_gap = 0; timed_out = 0;
    @(negedge clk);
    img_in = img; kernel_in = ker; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 200) begin
      if (bus0.out_valid && out_ready && n_out < 16) begin
        got_data[n_out] = bus0.out_data;
        got_idx[n_out]  = bus0.out_idx;
        got_relu[n_out] = bus1.out_data;
        n_out++;
        last_hs = cyc;
      end
      if (done0) begin
        n_done++;
        done_cyc = cyc;
      end
      if (!busy0 && n_done == 0) busy_gap++;
      if (n_out == 16 && !busy0) break;
      if (mutate && cyc == 2) begin
        img_in = '0;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 200) timed_out = 1;
    done_gap = done_cyc - last_hs;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus0.out_valid !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 ||
        bus0.out_data !== '0 || bus0.out_idx !== 4'd0 || st0 !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset: valid=%b busy=%b done=%b data=%h idx=%0d st=%0d, want all 0 / IDLE",
               bus0.out_valid, busy0, done0, bus0.out_data, bus0.out_idx, st0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sum_ceiling();
    run_frame(ONES_IMG, PLUS1_KER, 1'b0);
    n_tests++;
    if (timed_out != 0 || n_out != 16) begin
      n_fail++;
      $display("FAIL ceiling_count: outputs=%0d timeout=%0d, want 16 / 0", n_out, timed_out);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (got_idx[i] !== 4'(i) || got_data[i] !== 8'd9) begin
        n_fail++;
        $display("FAIL ceiling_beat%0d: idx=%0d data=%0d, want idx=%0d data=9",
                 i, got_idx[i], got_data[i], i);
      end
    end
    n_tests++;
    if (n_done != 1 || done_gap != 1) begin
      n_fail++;
      $display("FAIL ceiling_done: pulses=%0d gap=%0d, want 1 / 1", n_done, done_gap);
    end
  endtask

  task automatic test_identity();
    logic [35:0] img = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) img[r*6+c] = 1'((r + c) & 1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) exp_q.push_back(ACC_W'((r + c + 2) & 1));
    run_frame(img, 36'h0_0001_0000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic [ACC_W-1:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (got_idx[i] !== 4'(i) || got_data[i] !== e) begin
        n_fail++;
        $display("FAIL identity_beat%0d: idx=%0d data=%0d, want idx=%0d data=%0d",
                 i, got_idx[i], got_data[i], i, e);
      end
    end
  endtask

  task automatic test_mixed();
    logic [35:0] ker;
    ker = ramp_kernel();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) exp_q.push_back(ACC_W'(ref_sum(MIXED_IMG, ker, r, c)));
    run_frame(MIXED_IMG, ker, 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic [ACC_W-1:0] e, er;
      e  = exp_q.pop_front();
      er = $signed(e) < 0 ? '0 : e;
      n_tests++;
      if (got_data[i] !== e || got_relu[i] !== er) begin
        n_fail++;
        $display("FAIL mixed_beat%0d: data=%h relu=%h, want data=%h relu=%h",
                 i, got_data[i], got_relu[i], e, er);
      end
    end
  endtask

  task automatic test_negative();
    run_frame(ONES_IMG, 36'h8_8888_8888, 1'b0);
    for (int i = 0; i < 16; i += 5) begin
      n_tests++;
      if (got_data[i] !== 8'hB8 || got_relu[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL negative_beat%0d: data=%h relu=%h, want B8 / 00", i, got_data[i], got_relu[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] e0, e1;
    logic [35:0] ker;
    int wait_cyc = 0;
    ker = ramp_kernel();
    e0 = ACC_W'(ref_sum(MIXED_IMG, ker, 0, 0));
    e1 = ACC_W'(ref_sum(MIXED_IMG, ker, 0, 1));
    @(negedge clk);
    img_in = MIXED_IMG; kernel_in = ker; out_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (bus0.out_valid !== 1'b0 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_compute: valid=%b busy=%b, want 0 / 1", bus0.out_valid, busy0);
    end
    @(negedge clk);
    n_tests++;
    if (bus0.out_valid !== 1'b1 || bus0.out_idx !== 4'd0 || bus0.out_data !== e0) begin
      n_fail++;
      $display("FAIL bp_first: valid=%b idx=%0d data=%h, want 1 / 0 / %h",
               bus0.out_valid, bus0.out_idx, bus0.out_data, e0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus0.out_valid !== 1'b1 || bus0.out_idx !== 4'd0 || bus0.out_data !== e0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b idx=%0d data=%h, want 1 / 0 / %h",
                 i, bus0.out_valid, bus0.out_idx, bus0.out_data, e0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (bus0.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drop: valid=%b, want 0 after handshake", bus0.out_valid);
    end
    @(negedge clk);
    n_tests++;
    if (bus0.out_valid !== 1'b1 || bus0.out_idx !== 4'd1 || bus0.out_data !== e1) begin
      n_fail++;
      $display("FAIL bp_next: valid=%b idx=%0d data=%h, want 1 / 1 / %h",
               bus0.out_valid, bus0.out_idx, bus0.out_data, e1);
    end
    out_ready = 1'b1;
    while (busy0 && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_tests++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: busy=%b after %0d cycles, want 0", busy0, wait_cyc);
    end
  endtask

  task automatic test_snapshot();
    run_frame(ONES_IMG, PLUS1_KER, 1'b1);
    n_tests++;
    if (timed_out != 0 || n_out != 16 || n_done != 1 || busy_gap != 0) begin
      n_fail++;
      $display("FAIL snap_frame: outputs=%0d done=%0d busy_gaps=%0d timeout=%0d, want 16/1/0/0",
               n_out, n_done, busy_gap, timed_out);
    end
    for (int i = 0; i < 16; i += 3) begin
      n_tests++;
      if (got_data[i] !== 8'd9) begin
        n_fail++;
        $display("FAIL snap_beat%0d: data=%0d, want 9", i, got_data[i]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL snap_retrigger: busy=%b, want 0", busy0);
    end
  endtask

  task automatic test_reset_midframe();
    int wait_cyc = 0;
    @(negedge clk);
    img_in = ONES_IMG; kernel_in = PLUS1_KER; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(bus0.out_valid && bus0.out_idx == 4'd7) && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_tests++;
    if (wait_cyc >= 100) begin
      n_fail++;
      $display("FAIL midreset_reach: idx7 not seen within %0d cycles", wait_cyc);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus0.out_valid !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || st0 !== ST_IDLE) begin
      n_fail++;
      $display("FAIL midreset_async: valid=%b busy=%b done=%b st=%0d, want 0/0/0/IDLE",
               bus0.out_valid, busy0, done0, st0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(ONES_IMG, PLUS1_KER, 1'b0);
    n_tests++;
    if (n_out != 16 || got_idx[0] !== 4'd0 || got_data[0] !== 8'd9) begin
      n_fail++;
      $display("FAIL midreset_restart: outputs=%0d idx0=%0d data0=%0d, want 16 / 0 / 9",
               n_out, got_idx[0], got_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_sum_ceiling();
    test_identity();
    test_mixed();
    test_negative();
    test_backpressure();
    test_snapshot();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
